// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the MEM stage and data memory. Stores retire in one
// cycle and drain in order; loads forward from the youngest matching entry.
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        cpu_mem_ctrl_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              stall_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic              mem_wr_valid_o,
    input  logic              mem_wr_ready_i,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [DATA_W-1:0] mem_wr_data_o
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] entry_addr [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;

    logic              full;
    logic              is_store;
    logic              is_load;
    logic              drain;
    logic              accept;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  idx;

    assign full     = (count == FULL_COUNT);
    assign is_store = cpu_mem_ctrl_i[1];
    assign is_load  = (cpu_mem_ctrl_i == 2'b01);

    assign mem_wr_valid_o = (count != '0);
    assign mem_wr_addr_o  = entry_addr[head];
    assign mem_wr_data_o  = entry_data[head];
    assign drain          = mem_wr_valid_o & mem_wr_ready_i;

    // A full buffer still accepts a store when the head drains in the same cycle.
    assign accept  = is_store & (~full | drain);
    assign stall_o = is_store & full & ~drain;
    assign empty_o = (count == '0);

    assign mem_rd_addr_o = cpu_addr_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (drain)
                head <= head + PTR_W'(1);
            if (accept)
                tail <= tail + PTR_W'(1);
            if (accept & ~drain)
                count <= count + (PTR_W+1)'(1);
            else if (drain & ~accept)
                count <= count - (PTR_W+1)'(1);
        end
    end

    // NOTE: entry storage has no reset; contents are only observed while count
    // marks them valid, so a reset path would be pure cost.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            entry_addr[tail] <= cpu_addr_i;
            entry_data[tail] <= cpu_wdata_i;
        end
    end

    // Walk from oldest to youngest so the last match found is the youngest.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (entry_addr[idx] == cpu_addr_i)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[idx];
            end
        end
    end

    assign cpu_rdata_o = (is_load & fwd_hit) ? fwd_data : mem_rd_data_i;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  cpu_mem_ctrl_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [31:0] cpu_rdata_o;
    logic        stall_o;
    logic        empty_o;
    logic [31:0] mem_rd_addr_o;
    logic [31:0] mem_rd_data_i;
    logic        mem_wr_valid_o;
    logic        mem_wr_ready_i;
    logic [31:0] mem_wr_addr_o;
    logic [31:0] mem_wr_data_o;

    store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_mem_ctrl_i (cpu_mem_ctrl_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_wdata_i    (cpu_wdata_i),
        .cpu_rdata_o    (cpu_rdata_o),
        .stall_o        (stall_o),
        .empty_o        (empty_o),
        .mem_rd_addr_o  (mem_rd_addr_o),
        .mem_rd_data_i  (mem_rd_data_i),
        .mem_wr_valid_o (mem_wr_valid_o),
        .mem_wr_ready_i (mem_wr_ready_i),
        .mem_wr_addr_o  (mem_wr_addr_o),
        .mem_wr_data_o  (mem_wr_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic        ready;
        logic        e_stall;
        logic        e_empty;
        logic        e_valid;
        logic [31:0] e_waddr;
        logic [31:0] e_wdata;
        logic        chk_rdata;
        logic [31:0] e_rdata;
    } vec_t;

    int  n_vec = 0;
    int  n_err = 0;
    wr_t model_q [$];
    wr_t wr_log  [$];
    wr_t exp_wr  [$];
    vec_t vecs [15];

    // Every accepted memory write, in the order the DUT performs them.
    always @(posedge clk_i) begin
        if (!rst_i && mem_wr_valid_o === 1'b1 && mem_wr_ready_i === 1'b1)
            wr_log.push_back('{addr: 64'(mem_wr_addr_o), data: 64'(mem_wr_data_o)});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] ctrl, input logic [31:0] addr, wdata, mrd,
                                input logic ready, e_stall, e_empty, e_valid,
                                input logic [31:0] e_waddr, e_wdata,
                                input logic chk_rdata, input logic [31:0] e_rdata);
        vec_t v;
        v.ctrl = ctrl; v.addr = addr; v.wdata = wdata; v.mrd = mrd; v.ready = ready;
        v.e_stall = e_stall; v.e_empty = e_empty; v.e_valid = e_valid;
        v.e_waddr = e_waddr; v.e_wdata = e_wdata;
        v.chk_rdata = chk_rdata; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic drive(input logic [1:0] c, input logic [31:0] a, wd, mrd, input logic rdy);
        cpu_mem_ctrl_i = c;
        cpu_addr_i     = a;
        cpu_wdata_i    = wd;
        mem_rd_data_i  = mrd;
        mem_wr_ready_i = rdy;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(2'b00, '0, '0, '0, 1'b0);
        tick();
        rst_i = 1'b0;
        model_q.delete();
        wr_log.delete();
        exp_wr.delete();
    endtask

    // One cycle checked against the reference model: expectations come from the
    // queue of buffered stores, then the queue is updated for the clock edge.
    task automatic mstep(input logic [1:0] c, input logic [31:0] a, wd, mrd, input logic rdy,
                         output logic stalled);
        logic        e_valid, e_drain, e_stall;
        logic [31:0] e_rdata;
        drive(c, a, wd, mrd, rdy);
        #1;
        e_valid = (model_q.size() != 0);
        e_drain = e_valid && rdy;
        e_stall = c[1] && (model_q.size() == DEPTH) && !e_drain;
        check("valid", 64'(mem_wr_valid_o), 64'(e_valid));
        check("empty", 64'(empty_o), 64'(!e_valid));
        check("stall", 64'(stall_o), 64'(e_stall));
        if (e_valid) begin
            check("wr_addr", 64'(mem_wr_addr_o), model_q[0].addr);
            check("wr_data", 64'(mem_wr_data_o), model_q[0].data);
        end
        if (c != 2'b11) begin
            e_rdata = mrd;
            if (c == 2'b01)
                for (int i = 0; i < model_q.size(); i++)
                    if (model_q[i].addr == 64'(a))
                        e_rdata = model_q[i].data[31:0];
            check("rdata", 64'(cpu_rdata_o), 64'(e_rdata));
            check("rd_addr", 64'(mem_rd_addr_o), 64'(a));
        end
        if (e_drain)
            exp_wr.push_back(model_q.pop_front());
        if (c[1] && !e_stall)
            model_q.push_back('{addr: 64'(a), data: 64'(wd)});
        stalled = e_stall;
        tick();
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, 64'(wr_log.size()), 64'(exp_wr.size()));
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
            check({name, "_addr"}, wr_log[i].addr, exp_wr[i].addr);
            check({name, "_data"}, wr_log[i].data, exp_wr[i].data);
        end
    endtask

    initial begin
        logic        st;
        logic [1:0]  pc;
        logic [31:0] pa, pw;
        logic        pending;
        int          r;

        rst_i = 1'b1;
        drive(2'b00, '0, '0, '0, 1'b0);
        tick();
        tick();

        // ---------------- table-driven directed sequence ----------------
        //          ctrl   addr   wdata  mrd    rdy  stl  emp  val  waddr  wdata chk rdata
        vecs[0]  = mk(2'b00, 32'h00, 32'h0, 32'h99, 0, 0, 1, 0, 32'h00, 32'h0, 1, 32'h99);
        vecs[1]  = mk(2'b10, 32'h20, 32'h1, 32'h00, 0, 0, 1, 0, 32'h00, 32'h0, 0, 32'h0);
        vecs[2]  = mk(2'b10, 32'h20, 32'h2, 32'h00, 0, 0, 0, 1, 32'h20, 32'h1, 0, 32'h0);
        vecs[3]  = mk(2'b01, 32'h20, 32'h0, 32'h55, 0, 0, 0, 1, 32'h20, 32'h1, 1, 32'h2);
        vecs[4]  = mk(2'b01, 32'h21, 32'h0, 32'h55, 0, 0, 0, 1, 32'h20, 32'h1, 1, 32'h55);
        vecs[5]  = mk(2'b10, 32'h22, 32'h3, 32'h00, 0, 0, 0, 1, 32'h20, 32'h1, 0, 32'h0);
        vecs[6]  = mk(2'b10, 32'h23, 32'h4, 32'h00, 0, 0, 0, 1, 32'h20, 32'h1, 0, 32'h0);
        vecs[7]  = mk(2'b10, 32'h24, 32'h5, 32'h00, 0, 1, 0, 1, 32'h20, 32'h1, 0, 32'h0);
        vecs[8]  = mk(2'b10, 32'h24, 32'h5, 32'h00, 1, 0, 0, 1, 32'h20, 32'h1, 0, 32'h0);
        vecs[9]  = mk(2'b01, 32'h20, 32'h0, 32'h77, 0, 0, 0, 1, 32'h20, 32'h2, 1, 32'h2);
        vecs[10] = mk(2'b01, 32'h24, 32'h0, 32'h77, 1, 0, 0, 1, 32'h20, 32'h2, 1, 32'h5);
        vecs[11] = mk(2'b00, 32'h00, 32'h0, 32'h00, 1, 0, 0, 1, 32'h22, 32'h3, 0, 32'h0);
        vecs[12] = mk(2'b00, 32'h00, 32'h0, 32'h00, 1, 0, 0, 1, 32'h23, 32'h4, 0, 32'h0);
        vecs[13] = mk(2'b01, 32'h24, 32'h0, 32'h66, 1, 0, 0, 1, 32'h24, 32'h5, 1, 32'h5);
        vecs[14] = mk(2'b01, 32'h24, 32'h0, 32'h66, 1, 0, 1, 0, 32'h00, 32'h0, 1, 32'h66);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, vecs[i].mrd, vecs[i].ready);
            #1;
            check($sformatf("v%0d_stall", i), 64'(stall_o), 64'(vecs[i].e_stall));
            check($sformatf("v%0d_empty", i), 64'(empty_o), 64'(vecs[i].e_empty));
            check($sformatf("v%0d_valid", i), 64'(mem_wr_valid_o), 64'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_waddr", i), 64'(mem_wr_addr_o), 64'(vecs[i].e_waddr));
                check($sformatf("v%0d_wdata", i), 64'(mem_wr_data_o), 64'(vecs[i].e_wdata));
            end
            if (vecs[i].chk_rdata)
                check($sformatf("v%0d_rdata", i), 64'(cpu_rdata_o), 64'(vecs[i].e_rdata));
            tick();
        end

        // ---------------- reset discards buffered stores ----------------
        do_reset();
        mstep(2'b10, 32'h40, 32'hA1, 32'h0, 1'b0, st);
        mstep(2'b10, 32'h41, 32'hA2, 32'h0, 1'b0, st);
        mstep(2'b10, 32'h42, 32'hA3, 32'h0, 1'b0, st);
        check("pre_reset_valid", 64'(mem_wr_valid_o), 64'(1));
        do_reset();
        check("rst_empty", 64'(empty_o), 64'(1));
        check("rst_valid", 64'(mem_wr_valid_o), 64'(0));
        check("rst_stall", 64'(stall_o), 64'(0));
        for (int i = 0; i < 3; i++)
            mstep(2'b00, 32'h0, 32'h0, 32'h0, 1'b1, st);
        check("rst_no_writes", 64'(wr_log.size()), 64'(0));

        // ---------------- in-order drain, ready from cycle 2 ----------------
        do_reset();
        mstep(2'b10, 32'h10, 32'hA, 32'h0, 1'b0, st);
        mstep(2'b10, 32'h11, 32'hB, 32'h0, 1'b1, st);
        mstep(2'b10, 32'h12, 32'hC, 32'h0, 1'b1, st);
        for (int i = 0; i < 3; i++)
            mstep(2'b00, 32'h0, 32'h0, 32'h0, 1'b1, st);
        check("order_n", 64'(wr_log.size()), 64'(3));
        if (wr_log.size() == 3) begin
            check("order0_addr", wr_log[0].addr, 64'h10);
            check("order0_data", wr_log[0].data, 64'hA);
            check("order1_addr", wr_log[1].addr, 64'h11);
            check("order1_data", wr_log[1].data, 64'hB);
            check("order2_addr", wr_log[2].addr, 64'h12);
            check("order2_data", wr_log[2].data, 64'hC);
        end
        check("order_empty", 64'(empty_o), 64'(1));

        // ---------------- wrap-around with toggling ready ----------------
        do_reset();
        begin
            int k = 1;
            int cyc = 0;
            while (k <= 10 && cyc < 200) begin
                mstep(2'b10, 32'h50 + 32'(k), 32'(k), 32'h0, cyc[0], st);
                if (!st) k++;
                cyc++;
            end
            check("wrap_all_accepted", 64'(k), 64'(11));
            for (int i = 0; i < 12; i++)
                mstep(2'b00, 32'h0, 32'h0, 32'h0, 1'(i % 2), st);
        end
        check("wrap_n", 64'(wr_log.size()), 64'(10));
        for (int i = 0; i < wr_log.size() && i < 10; i++)
            check("wrap_data", wr_log[i].data, 64'(i + 1));
        check_log("wrap");

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        pending = 1'b0;
        pc = 2'b00; pa = '0; pw = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pending) begin
                r  = $urandom_range(0, 19);
                pc = (r < 9) ? 2'b10 : (r < 16) ? 2'b01 : (r < 19) ? 2'b00 : 2'b11;
                pa = 32'($urandom_range(0, 7));
                pw = $urandom;
            end
            mstep(pc, pa, pw, $urandom, 1'($urandom_range(0, 2) == 0), st);
            pending = st;
        end
        for (int i = 0; i < 3 * DEPTH; i++)
            mstep(2'b00, 32'h0, 32'h0, 32'h0, 1'b1, st);
        check_log("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
